hazard_scoreboard: RTL

- Producer-side partner to the EX-stage forwarding mux: tracks in-flight register writers in a shadow EX/MEM/WB pipeline.
- Decides, while an instruction is in ID, which source each ALU operand (rs, rt/store data) takes in EX.
- Raises a load-use stall when forwarding cannot cover the dependency.
- Sits beside the ID/EX pipeline register in the 5-stage MIPS core.

---
 rtl/core_pkg.sv | 18 +
 rtl/hazard_scoreboard_fwd_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register address width, forwarding-select codes
// and the shadow pipeline slot used by the hazard scoreboard.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] dest;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// Per-source dependency comparator: picks the forwarding source for one ID
// operand and flags a dependency on a load still sitting in EX.
module fwd_match
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_use,
  input  slot_t                 i_ex,
  input  slot_t                 i_mem,
  input  slot_t                 i_wb,
  output logic [1:0]            o_sel,
  output logic                  o_load_hit
);

  logic w_src_live;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // $0 is hard-wired zero, so it never creates a dependency
  assign w_src_live = i_use && (i_src != '0);
  assign w_ex_hit   = w_src_live && i_ex.valid  && i_ex.we  && (i_ex.dest  == i_src);
  assign w_mem_hit  = w_src_live && i_mem.valid && i_mem.we && (i_mem.dest == i_src);
  assign w_wb_hit   = w_src_live && i_wb.valid  && i_wb.we  && (i_wb.dest  == i_src);

  assign o_load_hit = w_ex_hit && i_ex.is_load;

  always_comb begin
    o_sel = FWD_REG;
    if (w_ex_hit && !i_ex.is_load) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEMWB;
    end else if (w_wb_hit) begin
      // write-first register file already returns the WB value
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use stall and EX forwarding-select generator built on a shadow
// EX/MEM/WB writer pipeline. Define HAZARD_STATS_EN for a stall counter.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int STALL_CNT_W = 16
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_we,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  hold,
`ifdef HAZARD_STATS_EN
  input  logic                  stats_clr,
  output logic [STALL_CNT_W-1:0] stall_count,
`endif
  output logic                  stall,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [REG_ADDR_W-1:0] ex_busy_dest
);

  slot_t      r_ex;
  slot_t      r_mem;
  slot_t      r_wb;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_load_hit_a;
  logic       w_load_hit_b;
  logic       w_stall;
  logic       w_issue;
  slot_t      w_id_slot;

  fwd_match u_match_rs (
    .i_src      (id_rs),
    .i_use      (id_use_rs),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_sel_a),
    .o_load_hit (w_load_hit_a)
  );

  fwd_match u_match_rt (
    .i_src      (id_rt),
    .i_use      (id_use_rt),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_sel_b),
    .o_load_hit (w_load_hit_b)
  );

  // flush kills the ID instruction, so it also cancels any stall
  assign w_stall = id_valid && !flush && (w_load_hit_a || w_load_hit_b);
  assign w_issue = id_valid && !w_stall && !flush;

  always_comb begin
    w_id_slot         = '0;
    w_id_slot.valid   = 1'b1;
    w_id_slot.we      = id_we;
    w_id_slot.dest    = id_dest;
    w_id_slot.is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else if (!hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_issue) begin
        r_ex    <= w_id_slot;
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end else begin
        r_ex    <= '0;
        r_fwd_a <= FWD_REG;
        r_fwd_b <= FWD_REG;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (stats_clr) begin
      r_stall_count <= '0;
    end else if (!hold && w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign stall        = w_stall;
  assign fwd_sel_a    = r_fwd_a;
  assign fwd_sel_b    = r_fwd_b;
  assign ex_busy_dest = (r_ex.valid && r_ex.we) ? r_ex.dest : '0;

endmodule
